dcache_store_responder: RTL and testbench

// - Responder end of the D$ store request port: accepts non-speculative stores from the store buffer and grants them.
// - Holds granted stores in a small write queue and drains them in order to a backing memory write port.
// - Sits between the store buffer's dcache request port and the cache/memory write path.
// - Reports a page-offset hazard so that loads can wait for the queue to drain.

---
 rtl/dcache_store_responder_if.sv | 27 ++
 rtl/dcache_store_responder.sv | 166 ++++++++++++++++
 tb/tb_dcache_store_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_store_responder_if.sv
// Store request port between the store buffer (master) and the D$ store responder (slave).
// Address is split into a 12-bit page index and the remaining PLEN-12 tag bits.
interface dcache_store_responder_if #(
  parameter int unsigned PLEN = 56,
  parameter int unsigned XLEN = 64
);
  logic                  data_req;
  logic                  data_we;
  logic [11:0]           address_index;
  logic [PLEN-13:0]      address_tag;
  logic [XLEN-1:0]       data_wdata;
  logic [XLEN/8-1:0]     data_be;
  logic [1:0]            data_size;
  logic                  data_gnt;
  logic                  data_rvalid;
  logic [XLEN-1:0]       data_rdata;

  modport master (
    output data_req, data_we, address_index, address_tag, data_wdata, data_be, data_size,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, address_index, address_tag, data_wdata, data_be, data_size,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/dcache_store_responder.sv
// D$ store responder: grants stores into a small in-order write queue (optionally merging
// into the tail word) and drains it to a memory write port; flags page-offset hazards for loads.

module dcache_store_responder_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3,
  parameter int unsigned RW    = 1
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic [CW-1:0] count,
  input logic          pop,
  input logic          req,
  input logic          we,
  input logic          gnt,
  input logic [RW-1:0] req_bits
);
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> (count != '0));
  // Loads are never served on this port.
  a_no_load: assert property (@(posedge clk_i) disable iff (!rst_ni) req |-> we);
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (req && !gnt) |=> (req && $stable(req_bits)));
endmodule

module dcache_store_responder #(
  parameter int unsigned PLEN     = 56,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned COALESCE = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  dcache_store_responder_if.slave    req_port,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [PLEN-1:0]            mem_addr_o,
  output logic [XLEN-1:0]            mem_wdata_o,
  output logic [XLEN/8-1:0]          mem_be_o,
  input  logic [11:0]                page_offset_i,
  output logic                       page_offset_matches_o,
  output logic                       empty_o
);
  localparam int unsigned BW  = XLEN / 8;
  localparam int unsigned OFF = $clog2(BW);
  localparam int unsigned WAW = PLEN - OFF;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CNT_TWO = CW'(32'd2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WAW-1:0]  addr_r  [DEPTH];
  logic [XLEN-1:0] data_r  [DEPTH];
  logic [BW-1:0]   be_r    [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0]   wptr_r;
  logic [PW-1:0]   rptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_n_s;

  logic [PLEN-1:0] req_addr_s;
  logic [WAW-1:0]  req_waddr_s;
  logic [PW-1:0]   tail_s;
  logic            hit_s;
  logic            gnt_s;
  logic            push_s;
  logic            merge_s;
  logic            pop_s;
  logic            match_s;
  logic            unused_s;

  assign req_addr_s  = {req_port.address_tag, req_port.address_index};
  assign req_waddr_s = req_addr_s[PLEN-1:OFF];
  assign tail_s      = wptr_r - PTR_ONE;

  // With two or more entries the tail is never the head, so a merge cannot race a drain.
  assign hit_s   = (COALESCE != 32'd0) && (count_r >= CNT_TWO) && (addr_r[tail_s] == req_waddr_s);
  assign gnt_s   = req_port.data_req & req_port.data_we & (hit_s | (count_r < CNT_MAX));
  assign push_s  = gnt_s & ~hit_s;
  assign merge_s = gnt_s & hit_s;
  assign pop_s   = mem_req_o & mem_gnt_i;

  assign req_port.data_gnt    = gnt_s;
  assign req_port.data_rvalid = 1'b0;
  assign req_port.data_rdata  = '0;

  assign mem_req_o   = (count_r != '0);
  assign mem_addr_o  = {addr_r[rptr_r], {OFF{1'b0}}};
  assign mem_wdata_o = data_r[rptr_r];
  assign mem_be_o    = be_r[rptr_r];
  assign empty_o     = (count_r == '0);
  assign page_offset_matches_o = match_s;

  assign unused_s = ^{req_port.data_size, req_addr_s[OFF-1:0], page_offset_i[OFF-1:0]};

  // Next occupancy: push and pop cancel; a merge never changes occupancy.
  always_comb begin
    count_n_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + CNT_ONE;
      2'b01:   count_n_s = count_r - CNT_ONE;
      default: count_n_s = count_r;
    endcase
  end

  // Hazard match over queued entries plus the store being granted this cycle.
  always_comb begin
    match_s = gnt_s & (req_waddr_s[11-OFF:0] == page_offset_i[11:OFF]);
    for (int i = 0; i < DEPTH; i++) begin
      match_s = match_s | (valid_r[i] & (addr_r[i][11-OFF:0] == page_offset_i[11:OFF]));
    end
  end

  // Write queue storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
        be_r[i]   <= '0;
      end
      valid_r <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        addr_r[wptr_r]  <= req_waddr_s;
        data_r[wptr_r]  <= req_port.data_wdata;
        be_r[wptr_r]    <= req_port.data_be;
        valid_r[wptr_r] <= 1'b1;
        wptr_r          <= wptr_r + PTR_ONE;
      end
      if (merge_s) begin
        for (int b = 0; b < BW; b++) begin
          if (req_port.data_be[b]) begin
            data_r[tail_s][8*b +: 8] <= req_port.data_wdata[8*b +: 8];
          end
        end
        be_r[tail_s] <= be_r[tail_s] | req_port.data_be;
      end
      if (pop_s) begin
        valid_r[rptr_r] <= 1'b0;
        rptr_r          <= rptr_r + PTR_ONE;
      end
      count_r <= count_n_s;
    end
  end

  dcache_store_responder_chk #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .RW    (1 + PLEN + XLEN + BW)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .count    (count_r),
    .pop      (pop_s),
    .req      (req_port.data_req),
    .we       (req_port.data_we),
    .gnt      (gnt_s),
    .req_bits ({req_port.data_we, req_addr_s, req_port.data_wdata, req_port.data_be})
  );
endmodule

// File: tb/tb_dcache_store_responder.sv
// Self-checking bench: vector table for fill/stream, hand sequences for merge, hazard and reset,
// and a scoreboard of expected memory writes checked at every drained entry.
module tb_dcache_store_responder;
  typedef struct {
    logic [55:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        mem_gnt;
    logic        exp_gnt;
    logic        exp_req;
  } vec_t;

  typedef struct {
    logic [55:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_gnt;
  logic [55:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic [11:0] page_offset;
  logic        match;
  logic        empty;

  int checks   = 0;
  int failures = 0;
  wr_t sb[$];
  vec_t vecs[17];

  dcache_store_responder_if #(.PLEN(56), .XLEN(64)) rp ();

  dcache_store_responder #(.PLEN(56), .XLEN(64), .DEPTH(4), .COALESCE(1)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .req_port              (rp),
    .mem_req_o             (mem_req),
    .mem_gnt_i             (mem_gnt),
    .mem_addr_o            (mem_addr),
    .mem_wdata_o           (mem_wdata),
    .mem_be_o              (mem_be),
    .page_offset_i         (page_offset),
    .page_offset_matches_o (match),
    .empty_o               (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory-side scoreboard: every accepted write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected actual addr=%0h expected no write", mem_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        chk("mem_wdata", mem_wdata, e.data);
        chk("mem_be", 64'(mem_be), 64'(e.be));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b);
    rp.data_req      = 1'b1;
    rp.data_we       = 1'b1;
    rp.address_tag   = a[55:12];
    rp.address_index = a[11:0];
    rp.data_wdata    = d;
    rp.data_be       = b;
    rp.data_size     = 2'd3;
  endtask

  task automatic expect_wr(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b);
    wr_t e;
    e.addr = {a[55:3], 3'b000};
    e.data = d;
    e.be   = b;
    sb.push_back(e);
  endtask

  task automatic apply_vec(input int i);
    step();
    drive_store(vecs[i].addr, vecs[i].data, vecs[i].be);
    mem_gnt = vecs[i].mem_gnt;
    @(negedge clk);
    chk($sformatf("vec%0d_gnt", i), 64'(rp.data_gnt), 64'(vecs[i].exp_gnt));
    chk($sformatf("vec%0d_req", i), 64'(mem_req), 64'(vecs[i].exp_req));
    if (vecs[i].exp_gnt) expect_wr(vecs[i].addr, vecs[i].data, vecs[i].be);
  endtask

  task automatic drain(input string name);
    step();
    rp.data_req = 1'b0;
    mem_gnt     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (empty) break;
      step();
    end
    chk({name, "_empty"}, 64'(empty), 64'd1);
    chk({name, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      vecs[i].addr    = 56'h80000100 + 56'(8 * i);
      vecs[i].data    = 64'hF11F_0000_0000_0000 | 64'(i);
      vecs[i].be      = 8'hFF;
      vecs[i].mem_gnt = 1'b0;
      vecs[i].exp_gnt = (i < 4);
      vecs[i].exp_req = (i != 0);
    end
    for (int i = 0; i < 12; i++) begin
      vecs[5+i].addr    = 56'h80001000 + 56'(8 * i);
      vecs[5+i].data    = {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i * 3)};
      vecs[5+i].be      = 8'(8'h81 << (i % 7));
      vecs[5+i].mem_gnt = 1'b1;
      vecs[5+i].exp_gnt = 1'b1;
      vecs[5+i].exp_req = (i != 0);
    end

    rst_n = 1'b0;
    mem_gnt = 1'b0;
    page_offset = 12'h000;
    rp.data_req = 1'b0;
    rp.data_we = 1'b0;
    rp.address_tag = '0;
    rp.address_index = 12'h000;
    rp.data_wdata = 64'h0;
    rp.data_be = 8'h00;
    rp.data_size = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_gnt", 64'(rp.data_gnt), 64'd0);
    chk("rst_match", 64'(match), 64'd0);
    rst_n = 1'b1;

    // Single store: granted same cycle, visible to memory next cycle.
    step();
    drive_store(56'h80000010, 64'h1122334455667788, 8'hFF);
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("single_gnt", 64'(rp.data_gnt), 64'd1);
    chk("single_req_same_cycle", 64'(mem_req), 64'd0);
    expect_wr(56'h80000010, 64'h1122334455667788, 8'hFF);
    step();
    rp.data_req = 1'b0;
    @(negedge clk);
    chk("single_req_next", 64'(mem_req), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h80000010);
    step();
    @(negedge clk);
    chk("single_empty_after", 64'(empty), 64'd1);

    // Fill: four grants, fifth held until after a memory pop.
    for (int i = 0; i < 5; i++) apply_vec(i);
    step();
    @(negedge clk);
    chk("fill_held", 64'(rp.data_gnt), 64'd0);
    step();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("fill_held_during_pop", 64'(rp.data_gnt), 64'd0);
    step();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("fill_fifth_gnt", 64'(rp.data_gnt), 64'd1);
    expect_wr(vecs[4].addr, vecs[4].data, vecs[4].be);
    drain("fill");

    // Coalesce into tail W1 behind head W0.
    step();
    mem_gnt = 1'b0;
    drive_store(56'h80000200, 64'h0101010101010101, 8'hFF);
    @(negedge clk);
    chk("coal_w0_gnt", 64'(rp.data_gnt), 64'd1);
    expect_wr(56'h80000200, 64'h0101010101010101, 8'hFF);
    step();
    drive_store(56'h80000208, 64'h00000000AAAAAAAA, 8'h0F);
    @(negedge clk);
    chk("coal_a_gnt", 64'(rp.data_gnt), 64'd1);
    step();
    drive_store(56'h8000020C, 64'hBBBBBBBB00000000, 8'hF0);
    @(negedge clk);
    chk("coal_b_gnt", 64'(rp.data_gnt), 64'd1);
    expect_wr(56'h80000208, 64'hBBBBBBBBAAAAAAAA, 8'hFF);
    drain("coal");

    // Same word as the only (head) entry must allocate a new entry.
    step();
    mem_gnt = 1'b0;
    drive_store(56'h80000300, 64'h0000000012345678, 8'h0F);
    @(negedge clk);
    expect_wr(56'h80000300, 64'h0000000012345678, 8'h0F);
    step();
    drive_store(56'h80000300, 64'h9ABCDEF000000000, 8'hF0);
    @(negedge clk);
    chk("nocoal_gnt", 64'(rp.data_gnt), 64'd1);
    expect_wr(56'h80000300, 64'h9ABCDEF000000000, 8'hF0);
    drain("nocoal");

    // Continuous stream with memory always ready: pointers wrap.
    for (int i = 5; i < 17; i++) apply_vec(i);
    drain("stream");

    // Hazard detection, then asynchronous reset discards the queue.
    step();
    mem_gnt = 1'b0;
    drive_store(56'h80000238, 64'hDEADBEEFCAFEF00D, 8'hFF);
    @(negedge clk);
    expect_wr(56'h80000238, 64'hDEADBEEFCAFEF00D, 8'hFF);
    step();
    rp.data_req = 1'b0;
    page_offset = 12'h23C;
    @(negedge clk);
    chk("haz_match_23c", 64'(match), 64'd1);
    page_offset = 12'h240;
    #1;
    chk("haz_match_240", 64'(match), 64'd0);
    step();
    drive_store(56'h800005A0, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
    page_offset = 12'h5A4;
    @(negedge clk);
    chk("haz_match_inflight", 64'(match), 64'd1);
    expect_wr(56'h800005A0, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
    step();
    rp.data_req = 1'b0;
    page_offset = 12'h23C;
    @(negedge clk);
    chk("haz_pre_rst_match", 64'(match), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid_empty", 64'(empty), 64'd1);
    chk("rst_mid_match", 64'(match), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_mem_req", 64'(mem_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
